vred_pipe: RTL

Parametrised, fully pipelined vector reduction unit for the vALU. It folds a multi-beat vector source (vs2) into one scalar element, seeded from element 0 of vs1, and writes that scalar back through the lane's write port. It generalises the earlier fixed 64-bit reduction path in four ways: a configurable datapath width, per-element masking with identity substitution, signed/unsigned min/max, and an explicit error response for unsupported SEW. It sits beside the arithmetic lanes and has the same in_valid-only issue interface, with no backpressure.

---
 rtl/vred_pipe_if.sv | 29 ++
 rtl/vred_pipe.sv | 121 ++++++++++++
 2 files changed

// File: rtl/vred_pipe_if.sv
// vred_pipe_if: issue and writeback signals of the vector reduction unit
interface vred_pipe_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int BE_WIDTH = DATA_WIDTH / 8
);
  logic in_valid;
  logic in_start;
  logic in_end;
  logic [DATA_WIDTH-1:0] in_vec0;
  logic [DATA_WIDTH-1:0] in_vec1;
  logic [BE_WIDTH-1:0] in_mask;
  logic [2:0] in_opSel;
  logic [1:0] in_sew;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic out_valid;
  logic [DATA_WIDTH-1:0] out_vec;
  logic [BE_WIDTH-1:0] out_be;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic out_err;
  modport master (
    output in_valid, in_start, in_end, in_vec0, in_vec1, in_mask, in_opSel, in_sew, in_addr,
    input out_valid, out_vec, out_be, out_addr, out_err
  );
  modport slave (
    input in_valid, in_start, in_end, in_vec0, in_vec1, in_mask, in_opSel, in_sew, in_addr,
    output out_valid, out_vec, out_be, out_addr, out_err
  );
endinterface

// File: rtl/vred_pipe.sv
// vred_pipe: pipelined masked vector reduction of vs2 beats seeded by vs1[0]
module vred_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter bit ENABLE_64_BIT = 0,
  parameter int BE_WIDTH = DATA_WIDTH / 8
) (
  input logic clk,
  input logic rst,
  vred_pipe_if.slave bus
);
  // element values are kept zero-extended to 64 bits, truncated to SEW
  function automatic logic [63:0] msk(input logic [1:0] sew);
    return 64'hFFFF_FFFF_FFFF_FFFF >> (7'd64 - (7'd8 << sew));
  endfunction
  function automatic logic [63:0] ident(input logic [2:0] op, input logic [1:0] sew);
    logic [63:0] m;
    m = msk(sew);
    return (op == 3'b001 || op == 3'b100) ? m : op == 3'b101 ? m >> 1 : op == 3'b111 ? m ^ (m >> 1) : '0;
  endfunction
  function automatic logic [63:0] fold(input logic [63:0] a, b, input logic [2:0] op, input logic [1:0] sew);
    logic [63:0] m, h, sa, sb;
    logic lt;
    m = msk(sew);
    h = m ^ (m >> 1);
    sa = |(a & h) ? a | ~m : a;
    sb = |(b & h) ? b | ~m : b;
    lt = op[0] ? $signed(sa) < $signed(sb) : a < b;
    return op[2] ? ((lt ^ op[1]) ? a : b) : op[1:0] == 2'd0 ? (a + b) & m :
           op[1:0] == 2'd1 ? a & b : op[1:0] == 2'd2 ? a | b : a ^ b;
  endfunction
  typedef enum logic {IDLE, ACC} state_t;
  state_t state;
  logic s0_valid, s0_start, s0_end;
  logic [DATA_WIDTH-1:0] s0_vec;
  logic [63:0] s0_seed;
  logic [BE_WIDTH-1:0] s0_mask;
  logic [2:0] s0_op, h_op, eff_op, s1_op;
  logic [1:0] s0_sew, h_sew, eff_sew, s1_sew, s2_sew;
  logic [ADDR_WIDTH-1:0] s0_addr, s1_addr, s2_addr;
  logic s1_valid, s1_start, s1_end, s2_fin, take, err;
  logic [63:0] s1_tree, s1_seed, acc, acc_n;
  logic [3:0][63:0] tree;
  always_ff @(posedge clk) begin
    if (rst) s0_valid <= 1'b0;
    else s0_valid <= bus.in_valid;
    if (bus.in_valid) begin
      s0_start <= bus.in_start;
      s0_end <= bus.in_end;
      s0_vec <= bus.in_vec0;
      s0_seed <= bus.in_vec1[63:0];
      s0_mask <= bus.in_mask;
      s0_op <= bus.in_opSel;
      s0_sew <= bus.in_sew;
      s0_addr <= bus.in_addr;
    end
  end
  // beats outside a reduction are dropped; op and SEW come from the start beat
  assign take = s0_valid && (s0_start || state == ACC);
  assign eff_op = s0_start ? s0_op : h_op;
  assign eff_sew = s0_start ? s0_sew : h_sew;
  for (genvar s = 0; s < 4; s++) begin : g_tree
    localparam int W = 8 << s;
    localparam int N = DATA_WIDTH / W;
    logic [63:0] v [N];
    always_comb begin
      for (int i = 0; i < N; i++) v[i] = s0_mask[i] ? 64'(s0_vec[i*W +: W]) : ident(eff_op, 2'(s));
      for (int w = N / 2; w > 0; w = w / 2)
        for (int j = 0; j < w; j++) v[j] = fold(v[2*j], v[2*j+1], eff_op, 2'(s));
    end
    assign tree[s] = v[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= take;
      if (take) state <= s0_end ? IDLE : ACC;
    end
    if (s0_valid && s0_start) begin
      h_op <= s0_op;
      h_sew <= s0_sew;
    end
    s1_tree <= tree[eff_sew];
    s1_seed <= s0_seed & msk(s0_sew);
    s1_start <= s0_start;
    s1_end <= s0_end;
    s1_op <= eff_op;
    s1_sew <= eff_sew;
    s1_addr <= s0_addr;
  end
  assign acc_n = fold(s1_start ? s1_seed : acc, s1_tree, s1_op, s1_sew);
  always_ff @(posedge clk) begin
    if (rst) s2_fin <= 1'b0;
    else s2_fin <= s1_valid && s1_end;
    if (s1_valid) begin
      acc <= acc_n;
      s2_sew <= s1_sew;
      s2_addr <= s1_addr;
    end
  end
  assign err = s2_sew == 2'd3 && !ENABLE_64_BIT;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_err <= 1'b0;
      bus.out_vec <= '0;
      bus.out_be <= '0;
      bus.out_addr <= '0;
    end else begin
      bus.out_valid <= s2_fin;
      bus.out_err <= s2_fin && err;
      if (s2_fin) begin
        bus.out_vec <= err ? '0 : DATA_WIDTH'(acc);
        bus.out_be <= err ? '0 : BE_WIDTH'(8'hFF >> (4'd8 - (4'd1 << s2_sew)));
        bus.out_addr <= s2_addr;
      end
    end
  end
endmodule
